// File: rtl/tetris_vga_pkg.sv
// Shared definitions for the Tetris VGA path: board geometry, colours and pixel-slot mapping.
// Used by the pixel fetcher, the VGA output stage and the game logic.
package tetris_vga_pkg;

    localparam int unsigned BoardCols   = 10;
    localparam int unsigned BoardRows   = 20;
    localparam int unsigned CellSize    = 8;
    localparam int unsigned GroupPixels = 16;

    typedef logic [2:0] color_t;

    localparam color_t ColorBlack  = 3'b000;
    localparam color_t ColorBlue   = 3'b001;
    localparam color_t ColorGreen  = 3'b010;
    localparam color_t ColorRed    = 3'b100;
    localparam color_t ColorYellow = 3'b110;
    localparam color_t ColorWhite  = 3'b111;

    typedef enum logic [1:0] {StIdle, StRdA, StRdB, StCapB} fetch_state_e;

    // Bit position of pixel k inside a [0:47] pixel word; pixel 0 lives at [45:47].
    function automatic int unsigned pixel_slot(int unsigned k);
        return 45 - 3 * k;
    endfunction

endpackage

// File: rtl/tetris_word_pack.sv
// Builds one 16-pixel word from the two cell colours of a group, applying
// empty-cell background and optional grid lines.
module tetris_word_pack
    import tetris_vga_pkg::*;
#(
    parameter bit     GRID_EN    = 1'b1,
    parameter color_t BG_COLOR   = ColorBlack,
    parameter color_t GRID_COLOR = ColorBlue
) (
    input  logic [2:0]  color_a,
    input  logic [2:0]  color_b,
    input  logic        grid_row,
    output logic [0:47] word
);

    color_t shown_a;
    color_t shown_b;

    assign shown_a = (color_a == ColorBlack) ? BG_COLOR : color_a;
    assign shown_b = (color_b == ColorBlack) ? BG_COLOR : color_b;

    for (genvar k = 0; k < GroupPixels; k++) begin : g_pixel
        localparam int unsigned Slot     = pixel_slot(k);
        localparam bit          CellEdge = (k % CellSize) == 0;
        localparam bit          IsCellA  = k < CellSize;

        assign word[Slot +: 3] = (GRID_EN && (CellEdge || grid_row)) ? GRID_COLOR :
                                 (IsCellA ? shown_a : shown_b);
    end

endmodule

// File: rtl/tetris_pixel_fetch.sv
// Fetches board cells one group ahead of the VGA output stage and presents a stable
// 48-bit pixel word before its load point; also flags when the board RAM is being scanned.
module tetris_pixel_fetch
    import tetris_vga_pkg::*;
#(
    parameter int unsigned BOARD_G0   = 20,
    parameter int unsigned BOARD_V0   = 160,
    parameter color_t      BG_COLOR   = ColorBlack,
    parameter color_t      GRID_COLOR = ColorBlue,
    parameter bit          GRID_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [0:10] hcnt,
    input  logic [0:9]  vcnt,
    output logic        ram_rd_en,
    output logic [7:0]  ram_addr,
    input  logic [2:0]  ram_rdata,
    output logic [0:47] pixels,
    output logic        board_busy
);

    localparam int unsigned BoardLines  = BoardRows * CellSize;
    localparam int unsigned BoardGroups = BoardCols / 2;
    localparam logic [9:0]  V0          = 10'(BOARD_V0);
    localparam logic [6:0]  G0          = 7'(BOARD_G0);

    fetch_state_e state_q, state_d;
    logic         ram_rd_en_d;
    logic [7:0]   ram_addr_d;
    logic [0:47]  next_word_q, next_word_d;
    color_t       color_a_q, color_a_d;
    logic         grid_row_q, grid_row_d;
    logic [0:47]  pixels_d;
    logic [0:47]  packed_word;

    logic [4:0] phase;
    logic [6:0] ng;
    logic [6:0] j;
    logic [9:0] voff;
    logic [4:0] row;
    logic       v_on;
    logic       g_on;
    logic [7:0] addr_a;

    // The fetch works on the group after the current one, so the word is ready before its load.
    assign phase  = hcnt[6:10];
    assign ng     = {1'b0, hcnt[0:5]} + 7'd1;
    assign j      = ng - G0;
    assign voff   = vcnt - V0;
    assign row    = voff[7:3];
    assign v_on   = (vcnt >= V0) && (voff < 10'(BoardLines));
    assign g_on   = (ng >= G0) && (j < 7'(BoardGroups));
    assign addr_a = {row, 3'b000} + {2'b00, row, 1'b0} + {3'b000, j[3:0], 1'b0};

    tetris_word_pack #(
        .GRID_EN   (GRID_EN),
        .BG_COLOR  (BG_COLOR),
        .GRID_COLOR(GRID_COLOR)
    ) u_word_pack (
        .color_a (color_a_q),
        .color_b (ram_rdata),
        .grid_row(grid_row_q),
        .word    (packed_word)
    );

    always_comb begin
        state_d     = state_q;
        ram_rd_en_d = 1'b0;
        ram_addr_d  = ram_addr;
        next_word_d = next_word_q;
        color_a_d   = color_a_q;
        grid_row_d  = grid_row_q;
        pixels_d    = pixels;

        unique case (state_q)
            StIdle: begin
                if (phase == 5'd0) begin
                    next_word_d = {GroupPixels{BG_COLOR}};
                    if (v_on && g_on) begin
                        ram_rd_en_d = 1'b1;
                        ram_addr_d  = addr_a;
                        grid_row_d  = (voff[2:0] == 3'd0);
                        state_d     = StRdA;
                    end
                end
            end
            StRdA: begin
                ram_rd_en_d = 1'b1;
                ram_addr_d  = ram_addr + 8'd1;
                state_d     = StRdB;
            end
            StRdB: begin
                color_a_d = ram_rdata;
                state_d   = StCapB;
            end
            StCapB: begin
                next_word_d = packed_word;
                state_d     = StIdle;
            end
        endcase

        // Unconditional commit: an off-board group still presents its background word.
        if (phase == 5'd28) begin
            pixels_d = next_word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q     <= StIdle;
            ram_rd_en   <= 1'b0;
            ram_addr    <= '0;
            next_word_q <= '0;
            color_a_q   <= ColorBlack;
            grid_row_q  <= 1'b0;
            pixels      <= '0;
            board_busy  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_rd_en   <= ram_rd_en_d;
            ram_addr    <= ram_addr_d;
            next_word_q <= next_word_d;
            color_a_q   <= color_a_d;
            grid_row_q  <= grid_row_d;
            pixels      <= pixels_d;
            board_busy  <= v_on;
        end
    end

endmodule
